// File: rtl/regfile_wr_sched.sv
// Purpose: arbitrates requesters A and B onto the single register-file write port, and zeroes x1..x(NUM_REGS-1) after reset or on clear_req.
// Latency: an accepted write appears on w_en/w_addr/w_data one cycle after the handshake. The sweep takes NUM_REGS-1 cycles.
// Backpressure: at most one requester gets ready per cycle, round-robin on ties. Both readies are low while sweeping and in a cycle with clear_req.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   clear_req / busy       start a zeroing sweep (RUN only) / sweep in progress
//   a_valid/a_addr/a_data  requester A write request, a_ready = accepted this cycle
//   b_valid/b_addr/b_data  requester B write request, b_ready = accepted this cycle
//   w_en/w_addr/w_data     registered register-file write port
module regfile_wr_sched #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              w_en,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                w_en_q, w_en_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;

  logic                grant_a, grant_b;

  // On a tie the requester that did not win the last transfer goes first.
  assign grant_a = a_valid && (!b_valid || (last_grant_q == GNT_B));
  assign grant_b = b_valid && (!a_valid || (last_grant_q == GNT_A));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= FIRST_REG;
      last_grant_q <= GNT_B;
      w_en_q       <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      w_en_q       <= w_en_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    w_en_d       = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    busy         = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        busy     = 1'b1;
        w_en_d   = 1'b1;
        w_addr_d = cnt_q;
        w_data_d = '0;
        if (cnt_q == LAST_REG) begin
          // Leave the counter primed for the next sweep rather than letting it wrap.
          state_d = ST_RUN;
          cnt_d   = FIRST_REG;
        end else begin
          cnt_d = cnt_q + FIRST_REG;
        end
      end

      ST_RUN: begin
        if (clear_req) begin
          // No handshake in this cycle. A write registered last cycle still reaches the file.
          state_d = ST_CLEAR;
          cnt_d   = FIRST_REG;
        end else begin
          a_ready = grant_a;
          b_ready = grant_b;
          if (grant_a) begin
            // A write to x0 is accepted and counts for fairness, but never reaches the file.
            w_en_d       = (a_addr != '0);
            w_addr_d     = a_addr;
            w_data_d     = a_data;
            last_grant_d = GNT_A;
          end else if (grant_b) begin
            w_en_d       = (b_addr != '0);
            w_addr_d     = b_addr;
            w_data_d     = b_data;
            last_grant_d = GNT_B;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        cnt_d   = FIRST_REG;
      end
    endcase
  end

  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  assign w_data = w_data_q;

endmodule

// File: tb/tb_regfile_wr_sched.sv
module tb_regfile_wr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        busy;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        w_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_sched #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Moves to 1 time unit after the next rising edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks all 31 sweep cycles, ending in the first RUN cycle with w_addr=31 still visible.
  task automatic sweep(input string tag);
    for (int i = 0; i < 31; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_rdy"}, {30'd0, a_ready, b_ready}, 32'd0);
      tick();
      check({tag, "_wen"}, {31'd0, w_en}, 32'd1);
      check({tag, "_waddr"}, {27'd0, w_addr}, i + 1);
      check({tag, "_wdata"}, w_data, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #3;
    check("rst_wen", {31'd0, w_en}, 32'd0);
    check("rst_waddr", {27'd0, w_addr}, 32'd0);
    check("rst_wdata", w_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rdy", {30'd0, a_ready, b_ready}, 32'd0);

    // Sweep after reset release.
    tick();
    rst_n = 1'b1;
    sweep("sweep0");
    check("sweep0_done_busy", {31'd0, busy}, 32'd0);
    tick();
    check("sweep0_idle_wen", {31'd0, w_en}, 32'd0);

    // A-only write.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    check("aonly_ardy", {31'd0, a_ready}, 32'd1);
    check("aonly_brdy", {31'd0, b_ready}, 32'd0);
    tick();
    a_valid = 1'b0;
    check("aonly_wen", {31'd0, w_en}, 32'd1);
    check("aonly_waddr", {27'd0, w_addr}, 32'd5);
    check("aonly_wdata", w_data, 32'hDEADBEEF);
    tick();
    check("aonly_after_wen", {31'd0, w_en}, 32'd0);
    check("aonly_hold_waddr", {27'd0, w_addr}, 32'd5);
    check("aonly_hold_wdata", w_data, 32'hDEADBEEF);

    // B writes x0: it is accepted, but no write reaches the file.
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h12345678;
    #1;
    check("bzero_brdy", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 1'b0;
    check("bzero_wen", {31'd0, w_en}, 32'd0);

    // Both valid for 4 cycles. B won last, so the grants run A,B,A,B.
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA3A3A3A3;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB7B7B7B7;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_ardy", {31'd0, a_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_brdy", {31'd0, b_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("rr_wen", {31'd0, w_en}, 32'd1);
      check("rr_waddr", {27'd0, w_addr}, (i % 2 == 0) ? 32'd3 : 32'd7);
      check("rr_wdata", w_data, (i % 2 == 0) ? 32'hA3A3A3A3 : 32'hB7B7B7B7);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("rr_after_wen", {31'd0, w_en}, 32'd0);

    // clear_req while A is valid.
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99999999;
    clear_req = 1'b1;
    #1;
    check("clr_ardy", {31'd0, a_ready}, 32'd0);
    check("clr_busy_same", {31'd0, busy}, 32'd0);
    tick();
    clear_req = 1'b0;
    check("clr_no_xfer_wen", {31'd0, w_en}, 32'd0);
    sweep("sweep1");
    check("sweep1_done_busy", {31'd0, busy}, 32'd0);
    check("clr_first_run_ardy", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    check("clr_a_wen", {31'd0, w_en}, 32'd1);
    check("clr_a_waddr", {27'd0, w_addr}, 32'd9);
    check("clr_a_wdata", w_data, 32'h99999999);

    // Reset part-way through a sweep.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_waddr_before", {27'd0, w_addr}, 32'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", {31'd0, w_en}, 32'd0);
    check("mid_rst_waddr", {27'd0, w_addr}, 32'd0);
    check("mid_rst_wdata", w_data, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_restart_wen", {31'd0, w_en}, 32'd1);
    check("mid_restart_waddr", {27'd0, w_addr}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
